// File: rtl/inst_fetch_queue_if.sv
// Bundle of the fetch queue's bus-facing signals: redirect request from
// execute, the AHB-Lite instruction bus, and the decode handshake.
// master = fetch queue side, slave = bus/decode/execute side.
interface inst_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] HADDR;
  logic [1:0]      HTRANS;
  logic            HREADY;
  logic [XLEN-1:0] HRDATA;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  modport master (
    input  redirect, redirect_pc, HREADY, HRDATA, out_ready,
    output HADDR, HTRANS, out_valid, out_inst, out_pc, count
  );

  modport slave (
    output redirect, redirect_pc, HREADY, HRDATA, out_ready,
    input  HADDR, HTRANS, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: pipelined AHB-Lite word fetcher feeding a DEPTH-entry FIFO
// towards decode, with flush/redirect from execute.
// Optional early redirect on JAL: define INST_FETCH_JAL_PREDICT_EN.
module inst_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                CLK,
  input logic                reset,
  inst_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // Address phase driven but stalled by HREADY=0 (held stable on the bus)
  logic            ap_q, ap_d, ap_kill_q, ap_kill_d;
  logic [XLEN-1:0] ap_addr_q, ap_addr_d;
  // Address accepted, read data still to come
  logic            dp_q, dp_d, dp_kill_q, dp_kill_d;
  logic [XLEN-1:0] dp_addr_q, dp_addr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [CW:0]     occupancy;
  logic            issue_ok, addr_valid, addr_accept, data_done;
  logic            push, pop, out_valid, jal_hit;
  logic [XLEN-1:0] haddr, jal_target;

  assign out_valid = (count_q != '0);

  // Bus control, handshakes and next-state for the fetch and FIFO registers
  always_comb begin
    occupancy   = {1'b0, count_q} + (CW+1)'(dp_q) + (CW+1)'(ap_q);
    issue_ok    = occupancy < (CW+1)'(DEPTH);
    // A stalled address phase must stay on the bus even if a push since
    // then has filled the budget; during reset nothing is issued.
    addr_valid  = reset && (ap_q || issue_ok);
    haddr       = ap_q ? ap_addr_q : fetch_pc_q;
    addr_accept = addr_valid && bus.HREADY;
    data_done   = dp_q && bus.HREADY;
    push        = data_done && !dp_kill_q && !bus.redirect;
    pop         = out_valid && bus.out_ready && !bus.redirect;

`ifdef INST_FETCH_JAL_PREDICT_EN
    jal_hit    = data_done && !dp_kill_q && (bus.HRDATA[6:0] == 7'b1101111);
    jal_target = dp_addr_q + {{(XLEN-20){bus.HRDATA[31]}}, bus.HRDATA[19:12],
                              bus.HRDATA[20], bus.HRDATA[30:21], 1'b0};
`else
    jal_hit    = 1'b0;
    jal_target = '0;
`endif

    fetch_pc_d = fetch_pc_q;
    ap_d       = ap_q;
    ap_kill_d  = ap_kill_q;
    ap_addr_d  = ap_addr_q;
    dp_d       = dp_q;
    dp_kill_d  = dp_kill_q;
    dp_addr_d  = dp_addr_q;

    // Freshly driven address phase stalled: remember it so it stays put
    if (addr_valid && !bus.HREADY && !ap_q) begin
      ap_d      = 1'b1;
      ap_addr_d = haddr;
      ap_kill_d = 1'b0;
    end

    // HREADY=1 retires the data phase and accepts the address phase together
    if (bus.HREADY) begin
      dp_d      = addr_accept;
      ap_d      = 1'b0;
      ap_kill_d = 1'b0;
      if (addr_accept) begin
        dp_addr_d = haddr;
        dp_kill_d = ap_q && ap_kill_q;
        // A killed stalled phase was not fetched from fetch_pc, so no advance
        if (!(ap_q && ap_kill_q)) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
    end

    // Early JAL redirect: the request accepted on this edge is younger
    if (jal_hit) begin
      fetch_pc_d = jal_target;
      dp_kill_d  = 1'b1;
    end

    // External redirect overrides everything: kill all in-flight requests
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      dp_kill_d  = 1'b1;
      ap_kill_d  = 1'b1;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  // State registers; reset abandons any transfer in flight
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      ap_q       <= 1'b0;
      ap_kill_q  <= 1'b0;
      ap_addr_q  <= '0;
      dp_q       <= 1'b0;
      dp_kill_q  <= 1'b0;
      dp_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ap_q       <= ap_d;
      ap_kill_q  <= ap_kill_d;
      ap_addr_q  <= ap_addr_d;
      dp_q       <= dp_d;
      dp_kill_q  <= dp_kill_d;
      dp_addr_q  <= dp_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write: returned word plus the address it was fetched from
  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.HRDATA;
      pc_mem[wr_ptr_q]   <= dp_addr_q;
    end
  end

  assign bus.HADDR     = haddr;
  assign bus.HTRANS    = addr_valid ? HT_NONSEQ : HT_IDLE;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_valid ? inst_mem[rd_ptr_q] : '0;
  assign bus.out_pc    = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: zero/stalled-wait AHB memory model, scoreboard
// of expected (pc, inst) pairs consumed as decode accepts words.
module tb_inst_fetch_queue;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] slave_addr = '0;
  logic        jal_word_en = 1'b0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_inst_q[$];

  inst_fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus();

  inst_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .reset(reset), .bus(bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic jal_en);
    if (jal_en && a == 32'h20) return 32'h0100_006F;
    return a + 32'h13;
  endfunction

  // AHB slave: latch accepted address, return its word in the data phase
  always @(posedge CLK) begin
    if (bus.HREADY && bus.HTRANS == 2'b10) slave_addr <= bus.HADDR;
  end
  assign bus.HRDATA = mem_word(slave_addr, jal_word_en);

  // Scoreboard consumer: each accepted head must match the queue front
  always begin
    @(negedge CLK);
    #1;
    if (reset && !bus.redirect && bus.out_valid && bus.out_ready) begin
      n_cmp++;
      if (exp_pc_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: out_pc=%h out_inst=%h required no word", bus.out_pc, bus.out_inst);
      end else begin
        logic [31:0] pc_e, inst_e;
        pc_e = exp_pc_q.pop_front();
        inst_e = exp_inst_q.pop_front();
        if (bus.out_pc !== pc_e || bus.out_inst !== inst_e) begin
          n_bad++;
          $display("FAIL pop: out_pc=%h out_inst=%h required pc=%h inst=%h", bus.out_pc, bus.out_inst, pc_e, inst_e);
        end else begin
          $display("pop pc=%h inst=%h", bus.out_pc, bus.out_inst);
        end
      end
    end
  end

  task automatic load_seq(input logic [31:0] start, input int n);
    exp_pc_q.delete();
    exp_inst_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_pc_q.push_back(start + 32'(4 * i));
      exp_inst_q.push_back(mem_word(start + 32'(4 * i), jal_word_en));
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc, input int n);
    load_seq(pc & ~32'h3, n);
    bus.redirect = 1'b1;
    bus.redirect_pc = pc;
    @(negedge CLK);
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    n_cmp++; if (bus.HTRANS !== 2'b00) begin n_bad++; $display("FAIL reset_htrans: got %b required 00", bus.HTRANS); end
    n_cmp++; if (bus.HADDR !== 32'h0) begin n_bad++; $display("FAIL reset_haddr: got %h required 0", bus.HADDR); end
    n_cmp++; if (bus.out_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h required 0", bus.out_inst); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h required 0", bus.out_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] next_addr;
    next_addr = 32'h0;
    bus.HREADY = 1'b1;
    bus.out_ready = 1'b1;
    load_seq(32'h0, 40);
    reset = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge CLK);
      n_cmp++;
      if (bus.HTRANS !== 2'b10 || bus.HADDR !== next_addr) begin
        n_bad++;
        $display("FAIL stream_addr c=%0d: got htrans=%b haddr=%h required 10/%h", c, bus.HTRANS, bus.HADDR, next_addr);
      end
      next_addr += 32'h4;
      n_cmp++;
      if (bus.out_valid !== (c >= 2)) begin
        n_bad++;
        $display("FAIL stream_valid c=%0d: got %b required %b", c, bus.out_valid, (c >= 2));
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    do_redirect(32'h200, 40);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (bus.count > 3'd4) begin n_bad++; $display("FAIL bp_overflow: count=%0d required <=4", bus.count); end
      @(negedge CLK);
    end
    n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL bp_full: count=%0d required 4", bus.count); end
    n_cmp++; if (bus.HTRANS !== 2'b00) begin n_bad++; $display("FAIL bp_idle: htrans=%b required 00", bus.HTRANS); end
    n_cmp++; if (bus.out_pc !== 32'h200) begin n_bad++; $display("FAIL bp_head: out_pc=%h required 200", bus.out_pc); end
    bus.out_ready = 1'b1;
    repeat (10) @(negedge CLK);
    n_cmp++; if (bus.HTRANS !== 2'b10) begin n_bad++; $display("FAIL bp_resume: htrans=%b required 10", bus.HTRANS); end
  endtask

  task automatic test_wait_states();
    int k;
    bus.out_ready = 1'b1;
    do_redirect(32'h0, 40);
    for (k = 0; k < 20 && !(bus.HTRANS == 2'b10 && bus.HADDR == 32'hC); k++) @(negedge CLK);
    n_cmp++;
    if (!(bus.HTRANS == 2'b10 && bus.HADDR == 32'hC)) begin
      n_bad++; $display("FAIL ws_timeout: haddr=%h required C within 20 cycles", bus.HADDR);
    end
    bus.HREADY = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'hC) begin
        n_bad++; $display("FAIL ws_hold w=%0d: htrans=%b haddr=%h required 10/C", w, bus.HTRANS, bus.HADDR);
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_bad++; $display("FAIL ws_early w=%0d: out_valid=%b out_pc=%h required 0", w, bus.out_valid, bus.out_pc);
      end
    end
    bus.HREADY = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8) begin
      n_bad++; $display("FAIL ws_release: out_valid=%b out_pc=%h required 1/8", bus.out_valid, bus.out_pc);
    end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_redirect();
    int k;
    bus.out_ready = 1'b0;
    do_redirect(32'h0, 40);
    for (k = 0; k < 20 && bus.count != 3'd2; k++) @(negedge CLK);
    n_cmp++;
    if (bus.count !== 3'd2) begin n_bad++; $display("FAIL rd_timeout: count=%0d required 2", bus.count); end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL rd_pre_count: count=%0d required 2", bus.count); end
    n_cmp++;
    if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h14) begin
      n_bad++; $display("FAIL rd_pre_addr: htrans=%b haddr=%h required 10/14", bus.HTRANS, bus.HADDR);
    end
    do_redirect(32'h103, 40);
    n_cmp++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_flush: count=%0d out_valid=%b required 0/0", bus.count, bus.out_valid);
    end
    n_cmp++;
    if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h100) begin
      n_bad++; $display("FAIL rd_target: htrans=%b haddr=%h required 10/100", bus.HTRANS, bus.HADDR);
    end
    bus.out_ready = 1'b1;
    @(negedge CLK);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat1: out_valid=%b required 0", bus.out_valid); end
    @(negedge CLK);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
      n_bad++; $display("FAIL rd_lat2: out_valid=%b out_pc=%h required 1/100", bus.out_valid, bus.out_pc);
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    exp_pc_q.delete();
    exp_inst_q.delete();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      n_bad++; $display("FAIL rm_flush: out_valid=%b count=%0d required 0/0", bus.out_valid, bus.count);
    end
    n_cmp++;
    if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0) begin
      n_bad++; $display("FAIL rm_idle: htrans=%b haddr=%h required 00/0", bus.HTRANS, bus.HADDR);
    end
    repeat (3) @(negedge CLK);
    load_seq(32'h0, 40);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h0) begin
      n_bad++; $display("FAIL rm_resume: htrans=%b haddr=%h required 10/0", bus.HTRANS, bus.HADDR);
    end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_jal();
    logic [31:0] pc;
    logic [31:0] addr_c;
    jal_word_en = 1'b1;
    bus.out_ready = 1'b1;
    exp_pc_q.delete();
    exp_inst_q.delete();
    pc = 32'h20;
    for (int i = 0; i < 20; i++) begin
      exp_pc_q.push_back(pc);
      exp_inst_q.push_back(mem_word(pc, 1'b1));
`ifdef INST_FETCH_JAL_PREDICT_EN
      pc = (pc == 32'h20) ? 32'h30 : pc + 32'h4;
`else
      pc = pc + 32'h4;
`endif
    end
`ifdef INST_FETCH_JAL_PREDICT_EN
    addr_c = 32'h30;
`else
    addr_c = 32'h28;
`endif
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h20;
    @(negedge CLK);
    bus.redirect = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (bus.HTRANS !== 2'b10 || bus.HADDR !== addr_c) begin
      n_bad++; $display("FAIL jal_fetch: htrans=%b haddr=%h required 10/%h", bus.HTRANS, bus.HADDR, addr_c);
    end
    repeat (8) @(negedge CLK);
    jal_word_en = 1'b0;
  endtask

  initial begin
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.HREADY = 1'b1;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect();
    test_reset_mid();
    test_jal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
